// File: rtl/demod_sched_if.sv
// Bundle of request, engine and result signals for the demod scheduler.
// The scheduler connects through the slave modport; the driving environment uses master.
interface demod_sched_if #(
    parameter int NCH     = 4,
    parameter int BITS_IN = 8,
    parameter int BITS    = 16
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]         req_tick;
    logic [NCH*BITS_IN-1:0] req_I;
    logic [NCH*BITS_IN-1:0] req_Q;
    logic [BITS_IN-1:0]     eng_I;
    logic [BITS_IN-1:0]     eng_Q;
    logic                   eng_load_tick;
    logic [BITS-1:0]        eng_demod;
    logic                   eng_out_tick;
    logic [BITS-1:0]        demod_out;
    logic [CW-1:0]          out_ch;
    logic                   out_tick;
    logic [NCH-1:0]         overrun;
    logic                   overrun_clr;
    logic                   timeout_err;

    modport slave (
        input  req_tick, req_I, req_Q, eng_demod, eng_out_tick, overrun_clr,
        output eng_I, eng_Q, eng_load_tick, demod_out, out_ch, out_tick, overrun, timeout_err
    );

    modport master (
        output req_tick, req_I, req_Q, eng_demod, eng_out_tick, overrun_clr,
        input  eng_I, eng_Q, eng_load_tick, demod_out, out_ch, out_tick, overrun, timeout_err
    );
endinterface

// File: rtl/demod_sched.sv
// Round-robin scheduler sharing one I/Q demod engine among NCH one-deep request slots.
// Optional engine watchdog enabled by defining DEMOD_SCHED_TIMEOUT_EN.
module demod_sched #(
    parameter int NCH     = 4,
    parameter int BITS_IN = 8,
    parameter int BITS    = 16,
    parameter int TIMEOUT = 63
) (
    input  logic         CLK,
    input  logic         RSTb,
    demod_sched_if.slave bus
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t                    state_q;
    logic signed [BITS_IN-1:0] slot_i_q [NCH];
    logic signed [BITS_IN-1:0] slot_q_q [NCH];
    logic [NCH-1:0]            pending_q, pending_d;
    logic [NCH-1:0]            overrun_q, overrun_d;
    logic [NCH-1:0]            grant_oh, take;
    logic [CW-1:0]             rr_ptr_q, grant_q, grant_d, grant_inc, idx_v;
    logic                      found;
    int                        idx;
    logic signed [BITS_IN-1:0] eng_i_q, eng_q_q;
    logic signed [BITS-1:0]    demod_q;
    logic [CW-1:0]             out_ch_q;
    logic                      load_q, out_tick_q, timeout_q;

`ifdef DEMOD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt_q;
`endif

    // First pending channel at or after rr_ptr, wrapping modulo NCH
    always_comb begin
        found    = 1'b0;
        grant_d  = rr_ptr_q;
        grant_oh = '0;
        idx      = 0;
        idx_v    = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            idx_v = CW'(idx);
            if (!found && pending_q[idx_v]) begin
                found           = 1'b1;
                grant_d         = idx_v;
                grant_oh[idx_v] = 1'b1;
            end
        end
    end

    // A same-cycle retick of the granted channel re-arms it without counting as overrun
    assign take      = (state_q == IDLE) ? grant_oh : '0;
    assign pending_d = bus.req_tick | (pending_q & ~take);
    assign overrun_d = (bus.req_tick & pending_q & ~take) | (overrun_q & ~{NCH{bus.overrun_clr}});
    assign grant_inc = (grant_q == CW'(NCH - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            pending_q <= '0;
            overrun_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                slot_i_q[c] <= '0;
                slot_q_q[c] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            for (int c = 0; c < NCH; c++) begin
                if (bus.req_tick[c]) begin
                    slot_i_q[c] <= bus.req_I[c*BITS_IN +: BITS_IN];
                    slot_q_q[c] <= bus.req_Q[c*BITS_IN +: BITS_IN];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            eng_i_q    <= '0;
            eng_q_q    <= '0;
            demod_q    <= '0;
            out_ch_q   <= '0;
            load_q     <= 1'b0;
            out_tick_q <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef DEMOD_SCHED_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            load_q     <= 1'b0;
            out_tick_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= grant_d;
                        eng_i_q <= slot_i_q[grant_d];
                        eng_q_q <= slot_q_q[grant_d];
                        load_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef DEMOD_SCHED_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    if (bus.eng_out_tick) begin
                        demod_q    <= bus.eng_demod;
                        out_ch_q   <= grant_q;
                        out_tick_q <= 1'b1;
                        state_q    <= RESULT;
                    end
`ifdef DEMOD_SCHED_TIMEOUT_EN
                    else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        rr_ptr_q  <= grant_inc;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESULT: begin
                    rr_ptr_q <= grant_inc;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.eng_I         = eng_i_q;
    assign bus.eng_Q         = eng_q_q;
    assign bus.eng_load_tick = load_q;
    assign bus.demod_out     = demod_q;
    assign bus.out_ch        = out_ch_q;
    assign bus.out_tick      = out_tick_q;
    assign bus.overrun       = overrun_q;
    assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_demod_sched.sv
// Scoreboard bench for demod_sched: stimulus queues expected issues/results, a monitor pops them.
// Timeout scenario is exercised when DEMOD_SCHED_TIMEOUT_EN is defined.
module tb_demod_sched;
    localparam int NCH = 4;
    localparam int BI  = 8;
    localparam int B   = 16;

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    demod_sched_if #(.NCH(NCH), .BITS_IN(BI), .BITS(B)) bus ();

    demod_sched #(.NCH(NCH), .BITS_IN(BI), .BITS(B), .TIMEOUT(63)) dut (
        .CLK (CLK),
        .RSTb(RSTb),
        .bus (bus)
    );

    typedef struct {logic [7:0] i; logic [7:0] q; int cyc;} iss_t;
    typedef struct {logic [15:0] d; logic [1:0] ch; int cyc;} out_t;

    iss_t exp_iss[$];
    out_t exp_out[$];
    iss_t ei;
    out_t eo;

    int cyc = 0;
    int pass_cnt = 0, total = 0;
    int n_out = 0, n_iss = 0, n_to = 0, to_cyc = -1;
    logic [7:0] hold_i, hold_q;
    bit holding = 0, stable = 1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    endtask

    task automatic fail_evt(input string nm);
        total++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    // Monitor: compare every engine issue and every result against the queues
    always @(negedge CLK) begin
        if (!RSTb) begin
            holding = 0;
        end else begin
            if (holding && (bus.eng_I !== hold_i || bus.eng_Q !== hold_q)) stable = 0;
            if (bus.eng_load_tick) begin
                n_iss++;
                hold_i = bus.eng_I; hold_q = bus.eng_Q; holding = 1; stable = 1;
                if (exp_iss.size() == 0) fail_evt("unexpected_issue");
                else begin
                    ei = exp_iss.pop_front();
                    chk("issue_I", 32'(bus.eng_I), 32'(ei.i));
                    chk("issue_Q", 32'(bus.eng_Q), 32'(ei.q));
                    if (ei.cyc >= 0) chk("issue_cycle", 32'(cyc), 32'(ei.cyc));
                end
            end
            if (bus.out_tick) begin
                n_out++;
                if (exp_out.size() == 0) fail_evt("unexpected_out_tick");
                else begin
                    eo = exp_out.pop_front();
                    chk("demod_out", 32'(bus.demod_out), 32'(eo.d));
                    chk("out_ch", 32'(bus.out_ch), 32'(eo.ch));
                    chk("out_cycle", 32'(cyc), 32'(eo.cyc));
                    chk("eng_inputs_held", 32'(stable), 32'd1);
                end
                holding = 0;
            end
            if (bus.timeout_err) begin
                n_to++;
                to_cyc = cyc;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic drive_tick(input logic [3:0] m, input logic [31:0] iv, input logic [31:0] qv,
                              input logic clr = 1'b0);
        bus.req_tick = m; bus.req_I = iv; bus.req_Q = qv; bus.overrun_clr = clr;
        step();
        bus.req_tick = '0; bus.overrun_clr = 1'b0;
    endtask

    task automatic push_iss(input logic [7:0] i, input logic [7:0] q, input int c);
        iss_t e;
        e.i = i; e.q = q; e.cyc = c;
        exp_iss.push_back(e);
    endtask

    task automatic wait_load();
        int k = 0;
        while (!bus.eng_load_tick && k < 300) begin step(); k++; end
        if (!bus.eng_load_tick) fail_evt("load_wait_timeout");
    endtask

    task automatic respond(input int d, input logic [15:0] v, input int ch);
        out_t e;
        step(d);
        e.d = v; e.ch = 2'(ch); e.cyc = cyc + 1;
        exp_out.push_back(e);
        bus.eng_out_tick = 1'b1; bus.eng_demod = v;
        step();
        bus.eng_out_tick = 1'b0; bus.eng_demod = '0;
    endtask

    initial begin
        int n0, i0, lc;
        bus.req_tick = '0; bus.req_I = '0; bus.req_Q = '0;
        bus.eng_demod = '0; bus.eng_out_tick = 1'b0; bus.overrun_clr = 1'b0;
        RSTb = 1'b0;
        step(2);
        chk("rst_data", {bus.eng_I, bus.eng_Q, bus.demod_out}, 32'd0);
        chk("rst_ctrl", 32'({bus.out_ch, bus.overrun, bus.eng_load_tick, bus.out_tick, bus.timeout_err}), 32'd0);
        RSTb = 1'b1;
        step(2);

        // Round robin: two full rounds, rr_ptr wraps 3 -> 0 between them
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) push_iss(8'(c*16 + 1), 8'(c*16 + 2), -1);
            drive_tick(4'hF, 32'h31211101, 32'h32221202);
            for (int c = 0; c < 4; c++) begin
                wait_load();
                respond(c + 1, 16'(((r == 0) ? 16'hA000 : 16'hB000) + c), c);
            end
            step(2);
        end

        // Single request latency on channel 2
        push_iss(8'h10, 8'h20, cyc + 2);
        drive_tick(4'b0100, 32'h00100000, 32'h00200000);
        wait_load();
        respond(3, 16'h1600, 2);
        step(2);

        // Overrun on channel 1 while channel 0 is busy
        push_iss(8'h40, 8'h41, -1);
        drive_tick(4'b0001, 32'h00000040, 32'h00000041);
        wait_load();
        drive_tick(4'b0010, 32'h00000500, 32'h00000600);
        drive_tick(4'b0010, 32'h00000700, 32'h00000800);
        chk("overrun_set", 32'(bus.overrun), 32'h2);
        push_iss(8'h07, 8'h08, -1);
        respond(1, 16'h0C00, 0);
        wait_load();
        respond(2, 16'h0D01, 1);
        drive_tick(4'b0000, 32'h0, 32'h0, 1'b1);
        chk("overrun_clr", 32'(bus.overrun), 32'h0);

        // Overrun set coinciding with overrun_clr: set wins
        push_iss(8'h22, 8'h23, -1);
        drive_tick(4'b1100, 32'h33220000, 32'h34230000);
        wait_load();
        drive_tick(4'b1000, 32'h55000000, 32'h56000000, 1'b1);
        chk("overrun_set_wins", 32'(bus.overrun), 32'h8);
        push_iss(8'h55, 8'h56, -1);
        respond(1, 16'h2222, 2);
        wait_load();
        respond(1, 16'h3333, 3);
        drive_tick(4'b0000, 32'h0, 32'h0, 1'b1);
        chk("overrun_clr2", 32'(bus.overrun), 32'h0);

        // Retick of the granted channel in the grant cycle re-arms it, no overrun
        push_iss(8'h61, 8'h62, -1);
        drive_tick(4'b0001, 32'h00000061, 32'h00000062);
        drive_tick(4'b0001, 32'h00000071, 32'h00000072);
        chk("grant_cycle_no_overrun", 32'(bus.overrun), 32'h0);
        push_iss(8'h71, 8'h72, -1);
        wait_load();
        respond(1, 16'h6161, 0);
        wait_load();
        respond(1, 16'h7171, 0);
        step(2);

        // Spurious engine result while idle
        n0 = n_out; i0 = n_iss;
        bus.eng_out_tick = 1'b1; bus.eng_demod = 16'hDEAD;
        step();
        bus.eng_out_tick = 1'b0; bus.eng_demod = '0;
        step(3);
        chk("spurious_no_out_tick", 32'(n_out), 32'(n0));
        chk("spurious_no_issue", 32'(n_iss), 32'(i0));

        // Reset while in WAIT with another channel pending
        push_iss(8'h81, 8'h82, -1);
        drive_tick(4'b0010, 32'h00008100, 32'h00008200);
        wait_load();
        step();
        drive_tick(4'b0100, 32'h00900000, 32'h00910000);
        n0 = n_out; i0 = n_iss;
        RSTb = 1'b0;
        #2;
        chk("rst_wait_data", {bus.eng_I, bus.eng_Q, bus.demod_out}, 32'd0);
        chk("rst_wait_ctrl", 32'({bus.out_ch, bus.overrun, bus.eng_load_tick, bus.out_tick, bus.timeout_err}), 32'd0);
        @(posedge CLK); #1;
        RSTb = 1'b1;
        bus.eng_out_tick = 1'b1; bus.eng_demod = 16'hBEEF;
        step();
        bus.eng_out_tick = 1'b0; bus.eng_demod = '0;
        step(5);
        chk("rst_no_out_tick", 32'(n_out), 32'(n0));
        chk("rst_pending_cleared", 32'(n_iss), 32'(i0));

`ifdef DEMOD_SCHED_TIMEOUT_EN
        // Silent engine: timeout 64 cycles after the load pulse, then next channel issued
        push_iss(8'hA1, 8'hA2, -1);
        push_iss(8'hB1, 8'hB2, -1);
        n0 = n_out;
        drive_tick(4'b0011, 32'h0000B1A1, 32'h0000B2A2);
        wait_load();
        lc = cyc;
        for (int k = 0; k < 100 && to_cyc < 0; k++) step();
        chk("timeout_cycle", 32'(to_cyc), 32'(lc + 64));
        chk("timeout_no_out_tick", 32'(n_out), 32'(n0));
        wait_load();
        respond(1, 16'hB1B1, 1);
        step(2);
        chk("timeout_pulses", 32'(n_to), 32'd1);
`else
        // Without the watchdog the engine may take arbitrarily long
        push_iss(8'hC1, 8'hC2, -1);
        drive_tick(4'b0001, 32'h000000C1, 32'h000000C2);
        wait_load();
        lc = cyc;
        step(80);
        chk("long_wait_no_issue", 32'(n_iss), 32'(i0 + 1));
        respond(1, 16'hC1C1, 0);
        step(2);
        chk("timeout_tied_low", 32'(n_to), 32'd0);
`endif

        chk("issue_queue_drained", 32'(exp_iss.size()), 32'd0);
        chk("out_queue_drained", 32'(exp_out.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/demod_sched.md
DEMOD_SCHED -- requirements
Module: demod_sched

Interface
REQ-001 Parameter NCH, default 4, number of I/Q requester channels (2..8).
REQ-002 Parameter BITS_IN, default 8, I/Q sample width.
REQ-003 Parameter BITS, default 16, demodulated sample width.
REQ-004 Parameter TIMEOUT, default 63, maximum engine wait in cycles; only used with DEMOD_SCHED_TIMEOUT_EN.
REQ-005 CLK  in  1  single clock for all logic.
REQ-006 RSTb  in  1  reset; asynchronous assert, active-low.
REQ-007 req_tick  in  NCH  per-channel one-cycle pulse, new sample present.
REQ-008 req_I  in  NCH*BITS_IN  signed I samples; channel c at bits [c*BITS_IN +: BITS_IN].
REQ-009 req_Q  in  NCH*BITS_IN  signed Q samples; same packing as req_I.
REQ-010 eng_I, eng_Q  out  BITS_IN each  sample presented to the shared demod engine.
REQ-011 eng_load_tick  out  1  one-cycle start pulse to the engine.
REQ-012 eng_demod  in  BITS  engine result; valid only while eng_out_tick is high.
REQ-013 eng_out_tick  in  1  engine result-ready pulse.
REQ-014 demod_out  out  BITS  result of the most recently completed channel.
REQ-015 out_ch  out  clog2(NCH)  channel index of demod_out.
REQ-016 out_tick  out  1  one-cycle pulse; demod_out/out_ch valid.
REQ-017 overrun  out  NCH  sticky per-channel overwrite flags.
REQ-018 overrun_clr  in  1  pulse that clears all overrun bits.
REQ-019 timeout_err  out  1  one-cycle pulse on engine timeout.

Function
REQ-020 Each channel SHALL have a one-deep holding slot; req_tick[c] captures req_I/req_Q slice c into the slot and sets pending[c] on the same edge.
REQ-021 req_tick[c] while pending[c] is already set SHALL overwrite the slot, keep pending[c] set and set overrun[c].
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT and RESULT; encodings outside these SHALL return to IDLE.
REQ-023 IDLE: if any pending bit is set, grant the first pending channel at or after rr_ptr (wrapping modulo NCH), latch the grant, copy the slot to eng_I/eng_Q, clear pending[grant] and go to ISSUE; otherwise stay.
REQ-024 req_tick on the granted channel in the grant cycle SHALL win: pending stays set with the new data, and no overrun is flagged.
REQ-025 ISSUE: eng_load_tick = 1 for exactly this cycle, then go to WAIT.
REQ-026 eng_I/eng_Q SHALL stay constant from ISSUE until the cycle after eng_out_tick, because the engine samples its inputs late.
REQ-027 WAIT: on eng_out_tick, register eng_demod into demod_out and the grant into out_ch, and go to RESULT.
REQ-028 RESULT: out_tick = 1 for exactly this cycle, rr_ptr <= grant+1 modulo NCH, go to IDLE.
REQ-029 Latency: req_tick at cycle n on an idle scheduler with nothing pending gives eng_load_tick at n+2. eng_out_tick at cycle m gives out_tick at m+1. The next grant is possible at m+2.
REQ-030 eng_out_tick outside WAIT SHALL be ignored.
REQ-031 overrun_clr and a new overrun event on the same channel in one cycle: the set SHALL win.
REQ-032 Only one engine operation SHALL be outstanding at any time.

Reset
REQ-033 While RSTb = 0, the block SHALL be in IDLE with rr_ptr = 0 and pending, overrun, slots, eng_I, eng_Q, demod_out and out_ch all 0.
REQ-034 While RSTb = 0, eng_load_tick, out_tick and timeout_err SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation with no out_tick; an eng_out_tick arriving after reset release SHALL be ignored per REQ-030.

Configuration
REQ-036 Macro DEMOD_SCHED_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-037 With DEMOD_SCHED_TIMEOUT_EN, reaching TIMEOUT cycles without eng_out_tick SHALL pulse timeout_err for one cycle, advance rr_ptr to grant+1, return to IDLE and emit no out_tick.
REQ-038 Macro not defined: WAIT SHALL last indefinitely, no counter SHALL be synthesised, and timeout_err SHALL be tied to 0.

Verification
REQ-039 Single request: NCH=4, req_tick[2] with I=0x10, Q=0x20 at cycle 0 -> eng_load_tick at cycle 2 with eng_I=0x10, eng_Q=0x20; engine responds 0x1600 -> out_tick with demod_out=0x1600, out_ch=2.
REQ-040 Round-robin: all four channels ticked in the same cycle -> grants in order 0,1,2,3; a later retick of all four -> order 0,1,2,3 again, with rr_ptr wrapping 3->0.
REQ-041 Overrun: two req_tick[1] pulses, data 0x05 then 0x07, while busy on channel 0 -> overrun[1]=1 and channel 1 is issued with I=0x07; overrun_clr -> overrun=0.
REQ-042 Inputs held: eng_I/eng_Q toggling checked every cycle from ISSUE to eng_out_tick -> no change observed; a spurious eng_out_tick in IDLE -> no out_tick.
REQ-043 Timeout (macro defined, TIMEOUT=63): engine silent -> timeout_err pulse 64 cycles after eng_load_tick, no out_tick, next pending channel issued.
REQ-044 Reset in WAIT: RSTb low for 1 cycle -> outputs zero, pending cleared, no out_tick, and the late eng_out_tick is ignored.
